// File: rtl/arranque_if.sv
// Command/status bundle for the soft-start sequencer.
//   master : issues start/stop/rapido/lento and observes the stage enables and status.
//   slave  : the sequencer itself.
// Signals: start, stop, rapido, lento (commands); out_30, out_50, out_100 (one-hot stage
// enables); busy, done, state_o[2:0] (status).
interface arranque_if;
    logic       start;
    logic       stop;
    logic       rapido;
    logic       lento;
    logic       out_30;
    logic       out_50;
    logic       out_100;
    logic       busy;
    logic       done;
    logic [2:0] state_o;

    modport master (
        output start, stop, rapido, lento,
        input  out_30, out_50, out_100, busy, done, state_o
    );

    modport slave (
        input  start, stop, rapido, lento,
        output out_30, out_50, out_100, busy, done, state_o
    );
endinterface

// File: rtl/arranque_secuenciador.sv
// Motor soft-start sequencer: ramps 30% -> 50% -> 100% with one-hot stage enables,
// using an internal tick prescaler so it runs straight off the board clock.
// Ports:
//   clk    : system clock
//   reset  : synchronous reset, active-high
//   bus    : arranque_if.slave (start/stop/rapido/lento in; out_30/out_50/out_100,
//            busy, done, state_o out; all outputs registered)
// Parameters: PRESCALE (clk cycles per tick), DWELL_FAST / DWELL_SLOW (ticks per stage).
// Optional feature: define ARRANQUE_RAMP_DOWN_EN to ramp down through 50% and 30% on stop
// instead of dropping straight to idle.
module arranque_secuenciador #(
    parameter int unsigned PRESCALE   = 100000000,
    parameter int unsigned DWELL_FAST = 2,
    parameter int unsigned DWELL_SLOW = 5
) (
    input  logic       clk,
    input  logic       reset,
    arranque_if.slave  bus
);

    localparam int unsigned DWELL_MAX = (DWELL_FAST > DWELL_SLOW) ? DWELL_FAST : DWELL_SLOW;
    localparam int unsigned PW        = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
    localparam int unsigned DW        = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] FAST_LAST = DW'(DWELL_FAST - 1);
    localparam logic [DW-1:0] SLOW_LAST = DW'(DWELL_SLOW - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S30  = 3'd1,
        S50  = 3'd2,
        S100 = 3'd3,
        DN50 = 3'd4,
        DN30 = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] pre;
    logic [DW-1:0] dwell;
    logic          mode_slow;
    logic [DW-1:0] dwell_last;
    logic          tick_c;
    logic          dwell_end_c;

    // Tick and dwell-expiry detection; ramp-down stages always use the fast dwell.
    always_comb begin
        dwell_last  = mode_slow ? SLOW_LAST : FAST_LAST;
        if (state == DN50 || state == DN30) begin
            dwell_last = FAST_LAST;
        end
        tick_c      = (state != IDLE) && (pre == PRE_LAST);
        dwell_end_c = tick_c && (dwell == dwell_last);
    end

    // Next-state decode; stop outranks both start and a same-cycle dwell advance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start && !bus.stop && (bus.rapido ^ bus.lento)) begin
                    state_nxt = S30;
                end
            end
            S30: begin
                if (bus.stop) begin
`ifdef ARRANQUE_RAMP_DOWN_EN
                    state_nxt = DN30;
`else
                    state_nxt = IDLE;
`endif
                end else if (dwell_end_c) begin
                    state_nxt = S50;
                end
            end
            S50: begin
                if (bus.stop) begin
`ifdef ARRANQUE_RAMP_DOWN_EN
                    state_nxt = DN50;
`else
                    state_nxt = IDLE;
`endif
                end else if (dwell_end_c) begin
                    state_nxt = S100;
                end
            end
            S100: begin
                if (bus.stop) begin
`ifdef ARRANQUE_RAMP_DOWN_EN
                    state_nxt = DN50;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef ARRANQUE_RAMP_DOWN_EN
            DN50: begin
                if (dwell_end_c) begin
                    state_nxt = DN30;
                end
            end
            DN30: begin
                if (dwell_end_c) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters, latched mode and registered outputs (decoded from the next state
    // so the enables change on the same edge as the state).
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pre         <= '0;
            dwell       <= '0;
            mode_slow   <= 1'b0;
            bus.out_30  <= 1'b0;
            bus.out_50  <= 1'b0;
            bus.out_100 <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.state_o <= 3'd0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state) begin
                pre   <= '0;
                dwell <= '0;
            end else if (state != IDLE) begin
                if (tick_c) begin
                    pre <= '0;
                    // S100 is untimed; holding dwell there keeps it in range.
                    if (state != S100) begin
                        dwell <= dwell + DW'(1);
                    end
                end else begin
                    pre <= pre + PW'(1);
                end
            end

            if (state == IDLE && state_nxt == S30) begin
                mode_slow <= bus.lento;
            end

            bus.out_30  <= (state_nxt == S30) || (state_nxt == DN30);
            bus.out_50  <= (state_nxt == S50) || (state_nxt == DN50);
            bus.out_100 <= (state_nxt == S100);
            bus.busy    <= (state_nxt != IDLE);
            bus.done    <= (state != IDLE) && (state_nxt == IDLE);
            bus.state_o <= state_nxt;
        end
    end

endmodule

// File: tb/tb_arranque_secuenciador.sv
// Bench for arranque_secuenciador (PRESCALE=4, DWELL_FAST=2, DWELL_SLOW=3).
// Stimulus pushes hand-computed expected snapshots (cycle, state code, done) into a queue;
// an independent negedge monitor pops and compares when the cycle arrives.
// Handles both builds: with and without ARRANQUE_RAMP_DOWN_EN.
module tb_arranque_secuenciador;

    localparam int unsigned PRESCALE = 4;
    localparam int unsigned DF       = 2;
    localparam int unsigned DS       = 3;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arranque_if bus ();

    arranque_secuenciador #(
        .PRESCALE   (PRESCALE),
        .DWELL_FAST (DF),
        .DWELL_SLOW (DS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       dn;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string nm, input int c, input logic [2:0] st, input logic dn);
        exp_t e;
        e.cyc  = c;
        e.st   = st;
        e.dn   = dn;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic push_range(input string nm, input int c0, input int c1, input logic [2:0] st);
        for (int c = c0; c <= c1; c++) push(nm, c, st, 1'b0);
    endtask

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            logic [5:0] want;
            logic [5:0] got;
            mon_e = q.pop_front();
            want  = {mon_e.st == 3'd1 || mon_e.st == 3'd5,
                     mon_e.st == 3'd2 || mon_e.st == 3'd4,
                     mon_e.st == 3'd3,
                     mon_e.st != 3'd0,
                     mon_e.dn,
                     1'b0};
            got   = {bus.out_30, bus.out_50, bus.out_100, bus.busy, bus.done, 1'b0};
            total++;
            if (mon_e.cyc != cyc) begin
                bad++;
                $display("FAIL %s late check at cyc=%0d, wanted cyc=%0d", mon_e.name, cyc, mon_e.cyc);
            end else if (got != want || bus.state_o != mon_e.st) begin
                bad++;
                $display("FAIL %s cyc=%0d got state=%0d o30/50/100/busy/done=%b want state=%0d %b",
                         mon_e.name, cyc, bus.state_o, got[5:1], mon_e.st, want[5:1]);
            end
        end
    end

    // Stop from a running stage whose stop path leads through DN50 (S50/S100).
    task automatic do_stop(input string nm);
        int t;
        t = cyc;
        bus.stop = 1'b1;
`ifdef ARRANQUE_RAMP_DOWN_EN
        push({nm, "_dn50"},   t + 1,  3'd4, 1'b0);
        push({nm, "_dn50e"},  t + 8,  3'd4, 1'b0);
        push({nm, "_dn30"},   t + 9,  3'd5, 1'b0);
        push({nm, "_dn30e"},  t + 16, 3'd5, 1'b0);
        push({nm, "_done"},   t + 17, 3'd0, 1'b1);
        push({nm, "_idle"},   t + 18, 3'd0, 1'b0);
`else
        push({nm, "_done"},   t + 1,  3'd0, 1'b1);
        push({nm, "_idle"},   t + 2,  3'd0, 1'b0);
`endif
        step(3);
        bus.stop = 1'b0;
        step(17);
    endtask

    initial begin
        int e0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.rapido = 1'b0;
        bus.lento  = 1'b0;
        step(3);
        push("reset", cyc, 3'd0, 1'b0);
        step(1);
        reset = 1'b0;
        push("post_reset", cyc + 1, 3'd0, 1'b0);
        step(2);

        // Fast ramp.
        e0 = cyc;
        bus.rapido = 1'b1;
        bus.lento  = 1'b0;
        bus.start  = 1'b1;
        push("fast_s30",     e0 + 1,  3'd1, 1'b0);
        push("fast_s30_end", e0 + 8,  3'd1, 1'b0);
        push("fast_s50",     e0 + 9,  3'd2, 1'b0);
        push("fast_s50_end", e0 + 16, 3'd2, 1'b0);
        push("fast_s100",    e0 + 17, 3'd3, 1'b0);
        push("fast_hold",    e0 + 22, 3'd3, 1'b0);
        step(1);
        bus.start = 1'b0;
        step(22);
        do_stop("fast_stop");

        // Slow ramp with mid-ramp mode toggling.
        e0 = cyc;
        bus.rapido = 1'b0;
        bus.lento  = 1'b1;
        bus.start  = 1'b1;
        push("slow_s30",     e0 + 1,  3'd1, 1'b0);
        push("slow_s30_end", e0 + 12, 3'd1, 1'b0);
        push("slow_s50",     e0 + 13, 3'd2, 1'b0);
        push("slow_s50_end", e0 + 24, 3'd2, 1'b0);
        push("slow_s100",    e0 + 25, 3'd3, 1'b0);
        push("slow_hold",    e0 + 28, 3'd3, 1'b0);
        step(1);
        bus.start = 1'b0;
        step(4);
        bus.rapido = 1'b1;
        step(10);
        bus.lento = 1'b0;
        step(14);
        do_stop("slow_stop");

        // Ambiguous mode selects: 1/1 then 0/0.
        e0 = cyc;
        bus.rapido = 1'b1;
        bus.lento  = 1'b1;
        bus.start  = 1'b1;
        push_range("bad_mode", e0 + 1, e0 + 5, 3'd0);
        step(2);
        bus.rapido = 1'b0;
        bus.lento  = 1'b0;
        step(3);
        bus.start = 1'b0;
        step(1);

        // start and stop together in IDLE.
        e0 = cyc;
        bus.rapido = 1'b1;
        bus.start  = 1'b1;
        bus.stop   = 1'b1;
        push_range("start_stop", e0 + 1, e0 + 3, 3'd0);
        step(2);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        step(2);

        // stop coinciding with the S30->S50 advance.
        e0 = cyc;
        bus.start = 1'b1;
        push("race_s30",     e0 + 1, 3'd1, 1'b0);
        push("race_s30_end", e0 + 8, 3'd1, 1'b0);
        step(1);
        bus.start = 1'b0;
        step(7);
        bus.stop = 1'b1;
`ifdef ARRANQUE_RAMP_DOWN_EN
        push_range("race_dn30", e0 + 9, e0 + 16, 3'd5);
        push("race_done", e0 + 17, 3'd0, 1'b1);
        push_range("race_idle", e0 + 18, e0 + 20, 3'd0);
`else
        push("race_done", e0 + 9, 3'd0, 1'b1);
        push_range("race_idle", e0 + 10, e0 + 20, 3'd0);
`endif
        step(1);
        bus.stop = 1'b0;
        step(13);

        // Reset mid-S30, then a clean restart.
        e0 = cyc;
        bus.start = 1'b1;
        push("rst_s30",   e0 + 1, 3'd1, 1'b0);
        push("rst_s30b",  e0 + 5, 3'd1, 1'b0);
        push("rst_clear", e0 + 6, 3'd0, 1'b0);
        push("rst_nodone", e0 + 7, 3'd0, 1'b0);
        step(1);
        bus.start = 1'b0;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(2);

        e0 = cyc;
        bus.start = 1'b1;
        push("re_s30",     e0 + 1,  3'd1, 1'b0);
        push("re_s30_end", e0 + 8,  3'd1, 1'b0);
        push("re_s50",     e0 + 9,  3'd2, 1'b0);
        push("re_s50_end", e0 + 16, 3'd2, 1'b0);
        push("re_s100",    e0 + 17, 3'd3, 1'b0);
        step(1);
        bus.start = 1'b0;
        step(19);
        do_stop("re_stop");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && q.size() > 0; i++) step(1);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain %0d expectations left unchecked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cyc=%0d, want finish before it", cyc);
        $fatal(1, "watchdog");
    end

endmodule
